// File: rtl/splitmix_stream.sv
// splitmix_stream: multi-lane SplitMix64 generator on a valid/ready stream.
// Three-stage elastic pipeline: Weyl add -> first mix -> second mix + finalise.
// Optional jump-ahead (skip_valid/skip_count) is built when SPLITMIX_SKIP_EN is defined.
module splitmix_stream #(
  parameter int          LANES = 1,
  parameter logic [63:0] GAMMA = 64'h9e3779b97f4a7c15,
  parameter logic [63:0] MIX1  = 64'hbf58476d1ce4e5b9,
  parameter logic [63:0] MIX2  = 64'h94d049bb133111eb
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  seed_valid,
  input  logic [63:0]           seed,
  input  logic                  run,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [64*LANES-1:0]   out_data,
  output logic [63:0]           state_out
`ifdef SPLITMIX_SKIP_EN
  ,
  input  logic                  skip_valid,
  input  logic [15:0]           skip_count
`endif
);

  // State advance per beat: every lane consumes one Weyl step.
  localparam logic [63:0] STEP = GAMMA * 64'(LANES);

  logic [63:0] state_reg;
  logic [63:0] state_next;
  logic        s0_valid_reg;
  logic        s1_valid_reg;
  logic        out_valid_reg;
  logic        out_load;
  logic        s1_load;
  logic        s0_load;
  logic        flush;
  logic        inject;

  // A stage loads when it is empty or the stage after it is taking its contents.
  assign out_load = !out_valid_reg || out_ready;
  assign s1_load  = !s1_valid_reg || out_load;
  assign s0_load  = !s0_valid_reg || s1_load;

`ifdef SPLITMIX_SKIP_EN
  logic        skip_take;
  logic [63:0] skip_delta;
  // A skip arriving together with a seed loses; the seed wins outright.
  assign skip_take  = skip_valid && !seed_valid;
  assign skip_delta = {48'd0, skip_count} * STEP;
  assign flush      = seed_valid || skip_valid;
`else
  assign flush      = seed_valid;
`endif

  // Seed/skip cycles never inject; the new state takes effect first.
  assign inject = run && s0_load && !flush;

  // Next state: seed load beats skip, skip beats normal injection.
  always_comb begin
    state_next = state_reg;
    if (seed_valid) begin
      state_next = seed;
`ifdef SPLITMIX_SKIP_EN
    end else if (skip_take) begin
      state_next = state_reg + skip_delta;
`endif
    end else if (inject) begin
      state_next = state_reg + STEP;
    end
  end

  // Generator state register, wraps mod 2^64.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= '0;
    end else begin
      state_reg <= state_next;
    end
  end

  // Stage valid bits; a flush discards every beat in flight, including the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_reg  <= 1'b0;
      s1_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (flush) begin
      s0_valid_reg  <= 1'b0;
      s1_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      if (out_load) out_valid_reg <= s1_valid_reg;
      if (s1_load)  s1_valid_reg  <= s0_valid_reg;
      if (s0_load)  s0_valid_reg  <= inject;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      // Lane k sits (k+1) Weyl steps past the current state.
      localparam logic [63:0] OFFSET = GAMMA * 64'(gi + 1);
      logic [63:0] a_reg;
      logic [63:0] b_reg;
      logic [63:0] o_reg;
      logic [63:0] b_calc;
      logic [63:0] c_calc;

      assign b_calc = (a_reg ^ (a_reg >> 30)) * MIX1;
      assign c_calc = (b_reg ^ (b_reg >> 27)) * MIX2;

      // Lane datapath registers; each moves only with its stage's load enable.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_reg <= '0;
          b_reg <= '0;
          o_reg <= '0;
        end else begin
          if (inject)   a_reg <= state_reg + OFFSET;
          if (s1_load)  b_reg <= b_calc;
          if (out_load) o_reg <= c_calc ^ (c_calc >> 31);
        end
      end

      assign out_data[64*gi +: 64] = o_reg;
    end
  endgenerate

  assign out_valid = out_valid_reg;
  assign state_out = state_reg;

endmodule

// File: tb/tb_splitmix_stream.sv
// Directed bench for splitmix_stream: one LANES=1 and one LANES=2 instance share stimulus.
module tb_splitmix_stream;

  localparam logic [63:0] GAMMA = 64'h9e3779b97f4a7c15;
  localparam logic [63:0] MIX1  = 64'hbf58476d1ce4e5b9;
  localparam logic [63:0] MIX2  = 64'h94d049bb133111eb;

  logic          clk;
  logic          rst_n;
  logic          seed_valid;
  logic [63:0]   seed;
  logic          run;
  logic          out_ready;
  logic          out_valid1;
  logic [63:0]   out_data1;
  logic [63:0]   state1;
  logic          out_valid2;
  logic [127:0]  out_data2;
  logic [63:0]   state2;
`ifdef SPLITMIX_SKIP_EN
  logic          skip_valid;
  logic [15:0]   skip_count;
`endif

  int n_checks;
  int n_fail;
  int exp_idx;

  splitmix_stream #(.LANES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid), .seed(seed), .run(run),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .state_out(state1)
`ifdef SPLITMIX_SKIP_EN
    , .skip_valid(skip_valid), .skip_count(skip_count)
`endif
  );

  splitmix_stream #(.LANES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid), .seed(seed), .run(run),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .state_out(state2)
`ifdef SPLITMIX_SKIP_EN
    , .skip_valid(skip_valid), .skip_count(skip_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference SplitMix64 output function applied to an already-advanced state.
  function automatic logic [63:0] mix(input logic [63:0] x);
    logic [63:0] z;
    z = (x ^ (x >> 30)) * MIX1;
    z = (z ^ (z >> 27)) * MIX2;
    return z ^ (z >> 31);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid1); end
    n_checks++;
    if (out_data1 !== 64'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", out_data1); end
    n_checks++;
    if (state1 !== 64'd0) begin n_fail++; $display("FAIL reset_state: got %h expected 0", state1); end
    n_checks++;
    if (out_data2 !== 128'd0) begin n_fail++; $display("FAIL reset_data2: got %h expected 0", out_data2); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    $display("reset released, state=%h", state1);
  endtask

  task automatic test_first_beats();
    run = 1'b1;
    tick();  // inject edge
    n_checks++;
    if (state1 !== GAMMA) begin n_fail++; $display("FAIL state_after_inject: got %h expected %h", state1, GAMMA); end
    n_checks++;
    if (state2 !== 64'h3c6ef372fe94f82a) begin n_fail++; $display("FAIL state2_after_inject: got %h expected 3c6ef372fe94f82a", state2); end
    n_checks++;
    if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL latency_edge1: got %b expected 0", out_valid1); end
    tick();
    n_checks++;
    if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL latency_edge2: got %b expected 0", out_valid1); end
    tick();
    n_checks++;
    if (out_valid1 !== 1'b1 || out_data1 !== 64'he220a8397b1dcdaf) begin
      n_fail++; $display("FAIL beat0: got v=%b %h expected v=1 e220a8397b1dcdaf", out_valid1, out_data1);
    end
    n_checks++;
    if (out_data2 !== {64'h6e789e6aa1b965f4, 64'he220a8397b1dcdaf}) begin
      n_fail++; $display("FAIL lanes2_beat0: got %h expected 6e789e6aa1b965f4e220a8397b1dcdaf", out_data2);
    end
    $display("beat0 lanes1=%h lanes2=%h", out_data1, out_data2);
    tick();
    n_checks++;
    if (out_data1 !== 64'h6e789e6aa1b965f4) begin n_fail++; $display("FAIL beat1: got %h expected 6e789e6aa1b965f4", out_data1); end
    n_checks++;
    if (out_data2 !== {64'hf88bb8a8724c81ec, 64'h06c45d188009454f}) begin
      n_fail++; $display("FAIL lanes2_beat1: got %h expected f88bb8a8724c81ec06c45d188009454f", out_data2);
    end
    tick();
    n_checks++;
    if (out_data1 !== 64'h06c45d188009454f) begin n_fail++; $display("FAIL beat2: got %h expected 06c45d188009454f", out_data1); end
    $display("beat1/beat2 checked, now showing %h", out_data1);
    exp_idx = 2;  // beat on the output now, accepted at the next edge
  endtask

  task automatic test_backpressure();
    logic [63:0] hold_data;
    logic [63:0] hold_state;
    logic [63:0] exp;
    int accepted;
    hold_data = '0;
    hold_state = '0;
    accepted = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = !(cyc >= 5 && cyc < 10);
      if (cyc == 5) begin
        hold_data = out_data1;
        hold_state = state1;
      end
      if (cyc > 5 && cyc < 10) begin
        n_checks++;
        if (out_valid1 !== 1'b1 || out_data1 !== hold_data) begin
          n_fail++; $display("FAIL stall_hold cyc%0d: got v=%b %h expected v=1 %h", cyc, out_valid1, out_data1, hold_data);
        end
      end
      if (cyc == 10) begin
        n_checks++;
        if (state1 !== hold_state) begin n_fail++; $display("FAIL stall_state: got %h expected %h", state1, hold_state); end
      end
      if (out_valid1 && out_ready) begin
        exp = mix(GAMMA * 64'(exp_idx + 1));
        n_checks++;
        if (out_data1 !== exp) begin n_fail++; $display("FAIL stream_beat%0d: got %h expected %h", exp_idx, out_data1, exp); end
        exp_idx++;
        accepted++;
      end
      tick();
    end
    n_checks++;
    if (accepted != 15) begin n_fail++; $display("FAIL stream_count: got %0d expected 15", accepted); end
    $display("backpressure: %0d beats accepted, last index %0d", accepted, exp_idx);
  endtask

  task automatic test_seed_flush();
    out_ready = 1'b0;
    tick();
    tick();
    n_checks++;
    if (out_valid1 !== 1'b1) begin n_fail++; $display("FAIL preseed_valid: got %b expected 1", out_valid1); end
    seed_valid = 1'b1;
    seed = 64'd0;
    tick();
    seed_valid = 1'b0;
    n_checks++;
    if (out_valid1 !== 1'b0 || out_valid2 !== 1'b0) begin
      n_fail++; $display("FAIL seed_flush: got v1=%b v2=%b expected 0 0", out_valid1, out_valid2);
    end
    n_checks++;
    if (state1 !== 64'd0) begin n_fail++; $display("FAIL seed_state: got %h expected 0", state1); end
    out_ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL seed_latency: got %b expected 0", out_valid1); end
    tick();
    n_checks++;
    if (out_valid1 !== 1'b1 || out_data1 !== 64'he220a8397b1dcdaf) begin
      n_fail++; $display("FAIL seed_beat0: got v=%b %h expected v=1 e220a8397b1dcdaf", out_valid1, out_data1);
    end
    $display("seed flush: first beat %h", out_data1);
  endtask

  task automatic test_wrap();
    logic [63:0] s;
    logic [63:0] exp;
    s = 64'hffffffffffffffff;
    seed_valid = 1'b1;
    seed = s;
    tick();
    seed_valid = 1'b0;
    n_checks++;
    if (state1 !== s) begin n_fail++; $display("FAIL wrap_seed: got %h expected %h", state1, s); end
    tick();
    n_checks++;
    if (state1 !== 64'h9e3779b97f4a7c14) begin n_fail++; $display("FAIL wrap_state: got %h expected 9e3779b97f4a7c14", state1); end
    tick();
    tick();
    exp = mix(64'h9e3779b97f4a7c14);
    n_checks++;
    if (out_valid1 !== 1'b1 || out_data1 !== exp) begin
      n_fail++; $display("FAIL wrap_beat0: got v=%b %h expected v=1 %h", out_valid1, out_data1, exp);
    end
    tick();
    exp = mix(s + GAMMA + GAMMA);
    n_checks++;
    if (out_data1 !== exp) begin n_fail++; $display("FAIL wrap_beat1: got %h expected %h", out_data1, exp); end
    $display("wrap: beats checked, state=%h", state1);
  endtask

  task automatic test_run_stop();
    int beats;
    logic [63:0] seen;
    beats = 0;
    seen = '0;
    run = 1'b0;
    seed_valid = 1'b1;
    seed = 64'd0;
    tick();
    seed_valid = 1'b0;
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid1) begin
        beats++;
        seen = out_data1;
      end
    end
    n_checks++;
    if (beats != 1) begin n_fail++; $display("FAIL runstop_count: got %0d expected 1", beats); end
    n_checks++;
    if (seen !== 64'he220a8397b1dcdaf) begin n_fail++; $display("FAIL runstop_data: got %h expected e220a8397b1dcdaf", seen); end
    n_checks++;
    if (state1 !== GAMMA) begin n_fail++; $display("FAIL runstop_state: got %h expected %h", state1, GAMMA); end
    $display("run stop: %0d beat drained", beats);
  endtask

  task automatic test_reset_midstream();
    run = 1'b1;
    tick();
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid1 !== 1'b0 || out_data1 !== 64'd0 || state1 !== 64'd0) begin
      n_fail++; $display("FAIL async_reset: got v=%b d=%h s=%h expected 0 0 0", out_valid1, out_data1, state1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    n_checks++;
    if (out_valid1 !== 1'b1 || out_data1 !== 64'he220a8397b1dcdaf) begin
      n_fail++; $display("FAIL post_reset_beat: got v=%b %h expected v=1 e220a8397b1dcdaf", out_valid1, out_data1);
    end
    $display("mid-stream reset: first beat %h", out_data1);
  endtask

`ifdef SPLITMIX_SKIP_EN
  task automatic test_skip();
    run = 1'b0;
    seed_valid = 1'b1;
    seed = 64'd0;
    tick();
    seed_valid = 1'b0;
    skip_valid = 1'b1;
    skip_count = 16'd2;
    run = 1'b1;
    tick();
    skip_valid = 1'b0;
    n_checks++;
    if (state1 !== 64'h3c6ef372fe94f82a) begin n_fail++; $display("FAIL skip_state: got %h expected 3c6ef372fe94f82a", state1); end
    tick();
    tick();
    tick();
    n_checks++;
    if (out_valid1 !== 1'b1 || out_data1 !== 64'h06c45d188009454f) begin
      n_fail++; $display("FAIL skip_beat: got v=%b %h expected v=1 06c45d188009454f", out_valid1, out_data1);
    end
    seed_valid = 1'b1;
    seed = 64'd0;
    skip_valid = 1'b1;
    skip_count = 16'd5;
    tick();
    seed_valid = 1'b0;
    skip_valid = 1'b0;
    n_checks++;
    if (state1 !== 64'd0) begin n_fail++; $display("FAIL skip_vs_seed_state: got %h expected 0", state1); end
    tick();
    tick();
    tick();
    n_checks++;
    if (out_data1 !== 64'he220a8397b1dcdaf) begin n_fail++; $display("FAIL skip_vs_seed_beat: got %h expected e220a8397b1dcdaf", out_data1); end
    $display("skip: jump and seed priority checked");
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail = 0;
    exp_idx = 0;
    rst_n = 1'b0;
    seed_valid = 1'b0;
    seed = 64'd0;
    run = 1'b0;
    out_ready = 1'b1;
`ifdef SPLITMIX_SKIP_EN
    skip_valid = 1'b0;
    skip_count = 16'd0;
`endif
    #1;
    test_reset();
    test_first_beats();
    test_backpressure();
    test_seed_flush();
    test_wrap();
    test_run_stop();
    test_reset_midstream();
`ifdef SPLITMIX_SKIP_EN
    test_skip();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
